freq_meter_sequencer: RTL and testbench
=======================================

// Module: freq_meter_sequencer
// PURPOSE
// - Gate-window sequencer and edge counter for the frequency-meter datapath.
// - Issues limp (clear), hab (count enable) and arm (latch/store) in the order
//   clear -> gate -> latch.
// - Counts rising edges of sig_in during a programmable gate window.
// - Publishes the count with a start/busy/done handshake; supports single-shot
//   and continuous measurement.
// PARAMETERS
// - GATE_W       16  width of gate_len and of the internal gate-cycle counter
// - CNT_W        16  width of edge counter and result
// PORTS
// - clk_controle  in   1       system clock; all logic on rising edge
// - reset         in   1       asynchronous, active-low reset
// - start         in   1       level-sampled request; accepted only in IDLE
// - continuous    in   1       1 = rearm automatically after DONE
// - gate_len      in   GATE_W  gate window length in clk cycles; sampled on start accept
// - sig_in        in   1       asynchronous signal under measurement
// - limp          out  1       clear strobe to downstream counter/display
// - hab           out  1       count enable (high for whole gate window)
// - arm           out  1       store strobe to downstream register
// - busy          out  1       high from start accept until DONE exits
// - done          out  1       1-cycle pulse; result/overflow valid
// - result        out  CNT_W   edges counted in last completed window
// - overflow      out  1       1 = last window's count saturated
// BEHAVIOUR
// - Reset (async, active-low): state=IDLE. limp/hab/arm/busy/done/overflow=0,
//   result=0, edge count=0, sync flops=0. Reset mid-measurement aborts
//   immediately; no partial result is published.
// - sig_in passes through a 2-flop synchroniser, then a rising-edge detector.
//   Detector output = sync_q & ~sync_qq (1-cycle strobe).
// - FSM states; all outputs registered and high exactly during the listed state:
//   - IDLE: all strobes 0, busy=0. On start=1: go to CLEAR and latch
//     gate_len (0 is treated as 1).
//   - CLEAR: limp=1, busy=1; edge count <= 0, gate counter <= 0.
//     Next: GATE.
//   - GATE: hab=1 for exactly N=latched gate_len cycles.
//     - Each edge strobe seen in a GATE cycle increments the count.
//     - Count saturates at 2^CNT_W-1 and sets an internal ovf flag.
//     - After the N-th cycle: go to SETTLE.
//   - SETTLE: 1 cycle, all strobes 0; edge strobes ignored. Next: LATCH.
//   - LATCH: arm=1; result <= count, overflow <= ovf. Next: DONE.
//   - DONE: done=1 for 1 cycle, busy still 1. Next: CLEAR if continuous=1
//     (re-uses latched gate_len), else IDLE.
// - Latency: start sampled at edge k.
//   - CLEAR occupies cycle k..k+1.
//   - done high in cycle k+N+3..k+N+4.
//   - busy high for N+4 cycles.
// - start while busy: ignored.
// - start held high at DONE with continuous=0: new accept on the next IDLE
//   cycle (1 idle cycle minimum).
// - continuous dropped mid-window: current measurement completes, then IDLE.
// - gate_len changes while busy: no effect until next accept from IDLE.
// - result/overflow hold their value between LATCH events, including across
//   IDLE; they are cleared only by reset.
// - Exactly one of limp/hab/arm may be high in any cycle; assert this.
// TESTING
// - Reset: assert reset=0 mid-GATE -> all outputs 0 within same cycle;
//   state IDLE after release; result=0.
// - Single shot: gate_len=100, sig_in period 4 clk (rising edge every 4),
//   start 1 cycle -> limp 1 cycle, hab 100 cycles, arm 1 cycle, done pulse;
//   result=25, overflow=0, busy 104 cycles.
// - Overflow: CNT_W=4, same stimulus -> result=15, overflow=1.
// - Continuous: continuous=1, gate_len=20, sig_in period 5 -> back-to-back
//   windows, done every 24 cycles, result=4 each. Drop continuous -> exactly
//   one further done, then IDLE.
// - Edge cases: gate_len=0 -> hab exactly 1 cycle. start pulses during GATE
//   -> ignored (single done). sig_in constant 1 -> result=0.
// - Sequencing check: limp, hab, arm never overlap. Order is always
//   limp -> hab -> arm -> done across 50 random gate_len/sig_in periods;
//   result matches the reference edge-count model.

Source files
------------

// File: rtl/freq_meter_sequencer.sv
// Gate-window sequencer and edge counter for the frequency meter.
// Drives limp (clear) -> hab (gate) -> arm (latch), then pulses done.
// The edge count saturates and is published with an overflow flag.
module freq_meter_sequencer #(
   parameter int GATE_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk_controle,
   input  logic              reset,
   input  logic              start,
   input  logic              continuous,
   input  logic [GATE_W-1:0] gate_len,
   input  logic              sig_in,
   output logic              limp,
   output logic              hab,
   output logic              arm,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  result,
   output logic              overflow
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_GATE   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_LATCH  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [GATE_W-1:0] len_lat;
   logic [GATE_W-1:0] gate_cnt;
   logic [CNT_W-1:0]  edge_cnt;
   logic              ovf;
   logic              sync_p0;
   logic              sync_p1;
   logic              sync_p2;
   logic              edge_stb;

   // Saturating increment of the edge count.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_ONE;
   endfunction

   // Zero-length windows run for one cycle so hab is never skipped.
   function automatic logic [GATE_W-1:0] clamp_len(input logic [GATE_W-1:0] l);
      return (l == '0) ? GATE_ONE : l;
   endfunction

   // Synchroniser (p0, p1) plus delay flop (p2) for rising-edge detection.
   always_ff @(posedge clk_controle or negedge reset) begin
      if (!reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         sync_p0 <= sig_in;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
      end
   end

   // ---- stage boundary: synchronised sig_in -> edge strobe ----
   assign edge_stb = sync_p1 & ~sync_p2;

   // Next-state selection for the measurement sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_CLEAR;
         S_CLEAR:  state_nxt = S_GATE;
         S_GATE:   if (gate_cnt == len_lat - GATE_ONE) state_nxt = S_SETTLE;
         S_SETTLE: state_nxt = S_LATCH;
         S_LATCH:  state_nxt = S_DONE;
         S_DONE:   state_nxt = continuous ? S_CLEAR : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register and strobes, registered from the next state so each
   // output is high exactly while its state is current.
   always_ff @(posedge clk_controle or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         limp  <= 1'b0;
         hab   <= 1'b0;
         arm   <= 1'b0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         limp  <= (state_nxt == S_CLEAR);
         hab   <= (state_nxt == S_GATE);
         arm   <= (state_nxt == S_LATCH);
         done  <= (state_nxt == S_DONE);
         busy  <= (state_nxt != S_IDLE);
      end
   end

   // Window length latch, gate counter, edge counter and published result.
   always_ff @(posedge clk_controle or negedge reset) begin
      if (!reset) begin
         len_lat  <= GATE_ONE;
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf      <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) len_lat <= clamp_len(gate_len);
            S_CLEAR: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               ovf      <= 1'b0;
            end
            S_GATE: begin
               gate_cnt <= gate_cnt + GATE_ONE;
               if (edge_stb) begin
                  if (edge_cnt == CNT_MAX) ovf <= 1'b1;
                  edge_cnt <= sat_inc(edge_cnt);
               end
            end
            S_LATCH: begin
               result   <= edge_cnt;
               overflow <= ovf;
            end
            default: ;
         endcase
      end
   end

   // Clear, gate and latch strobes must never overlap.
   always @(posedge clk_controle) begin
      if (reset) assert ($onehot0({limp, hab, arm}));
   end

endmodule

// File: tb/tb_freq_meter_sequencer.sv
// Bench for freq_meter_sequencer: directed and randomized windows checked
// against an edge-count model computed from the recorded sig_in history.
module tb_freq_meter_sequencer;

   logic        clk_controle = 1'b0;
   logic        reset        = 1'b0;
   logic        start        = 1'b0;
   logic        continuous   = 1'b0;
   logic        sig_in       = 1'b0;
   logic [15:0] gate_len     = 16'd0;

   logic        limp, hab, arm, busy, done, overflow;
   logic [15:0] result;
   logic        limp4, hab4, arm4, busy4, done4, overflow4;
   logic [3:0]  result4;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   bit hist [0:65535];
   int gen_mode   = 0;
   int period     = 4;
   int phase      = 0;
   bit const_val  = 1'b0;
   int kk         = 0;
   int prev_res   = 0;
   int prev_res4  = 0;

   freq_meter_sequencer dut (
      .clk_controle(clk_controle), .reset(reset), .start(start),
      .continuous(continuous), .gate_len(gate_len), .sig_in(sig_in),
      .limp(limp), .hab(hab), .arm(arm), .busy(busy), .done(done),
      .result(result), .overflow(overflow)
   );

   freq_meter_sequencer #(.CNT_W(4)) dut4 (
      .clk_controle(clk_controle), .reset(reset), .start(start),
      .continuous(continuous), .gate_len(gate_len), .sig_in(sig_in),
      .limp(limp4), .hab(hab4), .arm(arm4), .busy(busy4), .done(done4),
      .result(result4), .overflow(overflow4)
   );

   always #5 clk_controle = ~clk_controle;

   // Record the value of sig_in seen at every rising edge.
   always @(posedge clk_controle) begin
      hist[cyc] <= sig_in;
      cyc       <= cyc + 1;
   end

   // sig_in generator: periodic, random bits, or constant.
   always @(negedge clk_controle) begin
      case (gen_mode)
         0: begin
            phase  <= (phase + 1 >= period) ? 0 : phase + 1;
            sig_in <= (phase < period / 2);
         end
         1: sig_in <= 1'($urandom % 2);
         default: sig_in <= const_val;
      endcase
   end

   // Rising edges that fall inside gate cycles k+1..k+n (two-flop sync delay).
   function automatic int ref_count(input int k, input int n);
      int c = 0;
      for (int i = k + 1; i <= k + n; i++)
         if (hist[i-1] && !hist[i-2]) c++;
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Check one measurement window starting with CLEAR at cycle kk.
   task automatic check_window(input int n, input bit pulse_mid, input bit drop_cont);
      int exp_cnt;
      for (int i = kk; i <= kk + n + 3; i++) begin
         @(negedge clk_controle);
         if (i == kk) begin
            start = 1'b0;
            chk("hold_result", result, prev_res);
            chk("hold_result4", result4, prev_res4);
         end
         if (i == kk + 1) gate_len = 16'($urandom);
         if (pulse_mid && i == kk + 2) start = 1'b1;
         if (pulse_mid && i == kk + 3) start = 1'b0;
         if (drop_cont && i == kk + 2) continuous = 1'b0;
         chk("limp", limp, i == kk);
         chk("hab", hab, (i > kk) && (i <= kk + n));
         chk("arm", arm, i == kk + n + 2);
         chk("done", done, i == kk + n + 3);
         chk("busy", busy, 1);
         chk("strb4", {limp4, hab4, arm4, done4, busy4},
             {27'd0, i == kk, (i > kk) && (i <= kk + n), i == kk + n + 2, i == kk + n + 3, 1'b1});
         chk("onehot", $onehot0({limp, hab, arm}), 1);
      end
      exp_cnt = ref_count(kk, n);
      chk("result", result, (exp_cnt > 65535) ? 65535 : exp_cnt);
      chk("overflow", overflow, exp_cnt > 65535);
      chk("result4", result4, (exp_cnt > 15) ? 15 : exp_cnt);
      chk("overflow4", overflow4, exp_cnt > 15);
      prev_res  = (exp_cnt > 65535) ? 65535 : exp_cnt;
      prev_res4 = (exp_cnt > 15) ? 15 : exp_cnt;
      kk = kk + n + 4;
      if (!continuous) begin
         @(negedge clk_controle);
         chk("idle_busy", busy, 0);
         chk("idle_limp", limp, 0);
      end
   endtask

   task automatic launch(input int gl, input bit cont, input bit pulse_mid);
      gate_len   = 16'(gl);
      continuous = cont;
      start      = 1'b1;
      kk         = cyc;
      check_window((gl == 0) ? 1 : gl, pulse_mid, 1'b0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk_controle);
      chk("rst_strobes", {limp, hab, arm, busy, done, overflow}, 0);
      chk("rst_result", result, 0);
      chk("rst_strobes4", {limp4, hab4, arm4, busy4, done4, overflow4}, 0);
      reset = 1'b1;
      repeat (4) @(negedge clk_controle);
      chk("post_rst_busy", busy, 0);

      // Single shot, period 4, 100-cycle window
      gen_mode = 0; period = 4;
      repeat (4) @(negedge clk_controle);
      launch(100, 1'b0, 1'b0);
      chk("ss_result", result, 25);
      chk("ss_overflow", overflow, 0);
      chk("ss_result4", result4, 15);
      chk("ss_overflow4", overflow4, 1);

      // Continuous, period 5, 20-cycle windows; drop continuous in the third
      period = 5;
      repeat (6) @(negedge clk_controle);
      launch(20, 1'b1, 1'b0);
      chk("cont_result1", result, 4);
      check_window(20, 1'b0, 1'b0);
      chk("cont_result2", result, 4);
      check_window(20, 1'b0, 1'b1);
      chk("cont_result3", result, 4);
      repeat (3) @(negedge clk_controle);
      chk("cont_idle", busy, 0);

      // gate_len = 0 runs a one-cycle window
      launch(0, 1'b0, 1'b0);

      // start pulse during the gate is ignored
      launch(30, 1'b0, 1'b1);

      // Constant-high sig_in yields no edges
      gen_mode = 2; const_val = 1'b1;
      repeat (4) @(negedge clk_controle);
      launch(15, 1'b0, 1'b0);
      chk("const_result", result, 0);

      // Asynchronous reset in the middle of a window
      gen_mode   = 0; period = 3;
      gate_len   = 16'd50;
      continuous = 1'b0;
      start      = 1'b1;
      @(negedge clk_controle);
      start = 1'b0;
      repeat (10) @(negedge clk_controle);
      chk("pre_rst_hab", hab, 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_strobes", {limp, hab, arm, busy, done, overflow}, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_result4", result4, 0);
      @(negedge clk_controle);
      reset = 1'b1;
      repeat (5) @(negedge clk_controle);
      chk("after_rst_busy", busy, 0);
      chk("after_rst_result", result, 0);
      prev_res  = 0;
      prev_res4 = 0;

      // Randomized windows and sig_in patterns
      for (int r = 0; r < 50; r++) begin
         gen_mode = int'($urandom_range(0, 1));
         period   = int'($urandom_range(2, 9));
         repeat (3 + $urandom_range(0, 3)) @(negedge clk_controle);
         launch(int'($urandom_range(0, 40)), 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
